pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 109 ++++++++++
 tb/tb_pll_reset_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the PLL clock domain: holds sys_rst_n low until the PLL lock
// flag has been stable long enough, and re-asserts it on a sustained loss of lock.
`timescale 1ns/1ps
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOSS_FILTER        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       sys_rst_n,
    output logic       lock_lost,
    output logic [7:0] relock_count,
    output logic [1:0] fsm_state     // debug: 0 = WAIT_LOCK, 1 = STABLE, 2 = RUN
);

    localparam int STABLE_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int LOSS_W   = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [STABLE_W-1:0]   stable_q, stable_d;
    logic [LOSS_W-1:0]     loss_q, loss_d;
    logic [7:0]            relock_d;
    logic                  lost_d;
    logic                  lock_s;

    // pll_lock is asynchronous; only the last synchroniser stage is ever used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_LOCK;
            stable_q     <= '0;
            loss_q       <= '0;
            sys_rst_n    <= 1'b0;
            lock_lost    <= 1'b0;
            relock_count <= 8'd0;
        end else begin
            state_q      <= state_d;
            stable_q     <= stable_d;
            loss_q       <= loss_d;
            sys_rst_n    <= (state_d == RUN);
            lock_lost    <= lost_d;
            relock_count <= relock_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        loss_d   = '0;
        lost_d   = 1'b0;
        relock_d = relock_count;
        case (state_q)
            WAIT_LOCK: begin
                stable_d = '0;
                if (lock_s) state_d = STABLE;
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    stable_d = '0;
                end else if (stable_q == STABLE_LAST) begin
                    state_d  = RUN;
                    stable_d = '0;
                end else begin
                    stable_d = stable_q + 1'b1;
                end
            end
            RUN: begin
                // A dropout only counts once it has lasted LOSS_FILTER synchronised cycles.
                if (!lock_s) begin
                    if (loss_q == LOSS_LAST) begin
                        state_d = WAIT_LOCK;
                        lost_d  = 1'b1;
                        if (relock_count != 8'hFF) relock_d = relock_count + 8'd1;
                    end else begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = WAIT_LOCK;
                stable_d = '0;
            end
        endcase
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: a run-length reference model pushes the
// expected outputs per clock edge into a queue, and a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int LF   = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       sys_rst_n;
    logic       lock_lost;
    logic [7:0] relock_count;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .SYNC_STAGES       (SYNC),
        .LOCK_STABLE_CYCLES(LSC),
        .LOSS_FILTER       (LF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .sys_rst_n   (sys_rst_n),
        .lock_lost   (lock_lost),
        .relock_count(relock_count),
        .fsm_state   (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    logic [9:0] exp_q[$];   // {sys_rst_n, lock_lost, relock_count}
    logic       hist[$];    // pll_lock samples still inside the synchroniser
    int         vectors     = 0;
    int         miscompares = 0;
    bit         running;
    int         one_run, zero_run, relocks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Release after LSC+1 consecutive synchronised-high samples (one to leave WAIT_LOCK,
    // LSC more in STABLE); drop after LF consecutive synchronised-low samples while running.
    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
        running  = 1'b0;
        one_run  = 0;
        zero_run = 0;
        relocks  = 0;
    endtask

    task automatic model_edge(input logic p);
        logic ls;
        logic lost;
        ls = hist.pop_front();
        hist.push_back(p);
        lost = 1'b0;
        if (ls) begin
            one_run++;
            zero_run = 0;
        end else begin
            zero_run++;
            one_run = 0;
        end
        if (!running && one_run == LSC + 1) begin
            running = 1'b1;
        end else if (running && zero_run == LF) begin
            running = 1'b0;
            lost    = 1'b1;
            if (relocks < 255) relocks++;
        end
        exp_q.push_back({running, lost, 8'(relocks)});
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("edge_outputs", {22'd0, sys_rst_n, lock_lost, relock_count}, {22'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called between edges; drives pll_lock, lets one edge happen, models it.
    task automatic drive_cycle(input logic v);
        pll_lock = v;
        @(posedge clk);
        model_edge(v);
        #2;
    endtask

    task automatic hold(input logic v, input int n);
        repeat (n) drive_cycle(v);
    endtask

    // Mid-cycle rst_n pulse, placed after the monitor's negedge sample.
    task automatic pulse_reset();
        #4;
        rst_n = 1'b0;
        #1;
        check("pulse_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
        check("pulse_lock_lost", {31'd0, lock_lost}, 32'd0);
        check("pulse_relock", {24'd0, relock_count}, 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic v;
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("reset_sys_rst_n", {31'd0, sys_rst_n}, 32'd0);
        check("reset_lock_lost", {31'd0, lock_lost}, 32'd0);
        check("reset_relock", {24'd0, relock_count}, 32'd0);
        check("reset_state", {30'd0, fsm_state}, 32'd0);
        rst_n = 1'b1;

        hold(1'b0, 100);                 // no lock: stays in reset
        hold(1'b1, 20);                  // release on edge 11
        hold(1'b0, 3);                   // filtered dropout
        hold(1'b1, 10);
        hold(1'b0, 8);                   // sustained loss
        hold(1'b1, 5);                   // too short to release
        hold(1'b0, 3);
        hold(1'b1, 20);                  // release 11 edges after second rise
        pulse_reset();                   // reset while running
        hold(1'b1, 20);

        repeat (260) begin               // drive relock_count into saturation
            hold(1'b0, 6);
            hold(1'b1, 13);
        end
        @(negedge clk);
        #1;
        check("relock_saturated", {24'd0, relock_count}, 32'd255);
        #6;

        v = 1'b0;
        repeat (150) begin               // random lock waveform with occasional resets
            if ($urandom_range(0, 19) == 0) pulse_reset();
            hold(v, $urandom_range(1, 14));
            v = ~v;
        end

        hold(1'b0, 2);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
